// File: rtl/preemption_timer.sv
// User-mode quantum timer: counts (optionally prescaled) user cycles and raises a sticky
// context-switch interrupt once the quantum elapses, deferring it while a jump is in flight.
module preemption_timer #(
    parameter int COUNTER_WIDTH   = 8,
    parameter int DEFAULT_QUANTUM = 128,
    parameter int PRESCALE        = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     isUser,
    input  logic [5:0]               opcode,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [COUNTER_WIDTH-1:0] cfg_data,
    input  logic                     irq_ack,
    output logic                     irq,
    output logic [COUNTER_WIDTH-1:0] count
);

    localparam int CW = COUNTER_WIDTH;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [5:0] OP_JR  = 6'b010010;
    localparam logic [5:0] OP_JF  = 6'b010101;
    localparam logic [5:0] OP_J   = 6'b111100;
    localparam logic [5:0] OP_JTM = 6'b111101;
    localparam logic [5:0] OP_JAL = 6'b111110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EXPIRED,
        ST_PENDING
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   quantum_q, quantum_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            enable_q, enable_d;
    logic            periodic_q, periodic_d;
    logic [CW-1:0]   count_inc;
    logic            salto;

    assign salto     = opcode inside {OP_JR, OP_JF, OP_J, OP_JTM, OP_JAL};
    assign count_inc = count_q + CW'(1);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        count_d    = count_q;
        quantum_d  = quantum_q;
        presc_d    = presc_q;
        enable_d   = enable_q;
        periodic_d = periodic_q;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                presc_d = '0;
            end
            ST_COUNT: begin
                if (!isUser) begin
                    count_d = '0;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    count_d = count_inc;
                    if (quantum_q != '0 && count_inc == quantum_q) state_d = ST_EXPIRED;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_EXPIRED: begin
                // Kernel already running: the switch happened on its own, restart the quantum.
                if (!isUser) begin
                    state_d = ST_COUNT;
                    count_d = '0;
                    presc_d = '0;
                end else if (!salto) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (irq_ack) begin
                    count_d = '0;
                    presc_d = '0;
                    if (periodic_q) begin
                        state_d = ST_COUNT;
                    end else begin
                        state_d  = ST_IDLE;
                        enable_d = 1'b0;
                    end
                end
            end
        endcase

        // Configuration writes override the state machine, disable having top priority.
        if (cfg_we) begin
            if (!cfg_sel) begin
                quantum_d = cfg_data;
            end else begin
                periodic_d = cfg_data[1];
                if (!cfg_data[0]) begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                    count_d  = '0;
                    presc_d  = '0;
                end else begin
                    enable_d = 1'b1;
                    if (state_d == ST_IDLE) state_d = ST_COUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_COUNT;
            count_q    <= '0;
            quantum_q  <= CW'(DEFAULT_QUANTUM);
            presc_q    <= '0;
            enable_q   <= 1'b1;
            periodic_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            count_q    <= count_d;
            quantum_q  <= quantum_d;
            presc_q    <= presc_d;
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
        end
    end

    assign irq   = (state_q == ST_PENDING);
    assign count = count_q;

endmodule

// File: tb/tb_preemption_timer.sv
// Bench for preemption_timer: a vector table, directed latency sequences and a randomized
// run compared against a behavioural model, on a PRESCALE=1 and a PRESCALE=4 instance.
module tb_preemption_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       isUser = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [7:0] cfg_data = 8'd0;
    logic       irq_ack = 1'b0;
    logic       irq_a, irq_b;
    logic [7:0] count_a, count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    preemption_timer #(.COUNTER_WIDTH(8), .DEFAULT_QUANTUM(128), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .isUser(isUser), .opcode(opcode), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .irq_ack(irq_ack), .irq(irq_a), .count(count_a)
    );

    preemption_timer #(.COUNTER_WIDTH(8), .DEFAULT_QUANTUM(128), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .isUser(isUser), .opcode(opcode), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .irq_ack(irq_ack), .irq(irq_b), .count(count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; outputs are then looked at on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cfg_we  = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        isUser   = 1'b0;
        opcode   = 6'd0;
        cfg_we   = 1'b0;
        cfg_sel  = 1'b0;
        cfg_data = 8'd0;
        irq_ack  = 1'b0;
        @(negedge clk);
        check("reset irq", {31'd0, irq_a}, 32'd0);
        check("reset count", {24'd0, count_a}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until_irq(input int which, input int max, output int edges);
        edges = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if ((which == 0) ? irq_a : irq_b) begin
                edges = i;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       user;
        logic [5:0] op;
        logic       we;
        logic       sel;
        logic [7:0] data;
        logic       ack;
        logic       exp_irq;
        logic [7:0] exp_count;
    } vec_t;

    function automatic vec_t mk(input logic u, input logic [5:0] op, input logic we, input logic sel,
                                input logic [7:0] d, input logic ack, input logic ei, input logic [7:0] ec);
        vec_t v;
        v.user = u; v.op = op; v.we = we; v.sel = sel; v.data = d; v.ack = ack;
        v.exp_irq = ei; v.exp_count = ec;
        return v;
    endfunction

    // ---------------- behavioural model (randomized phase) ----------------
    bit m_en[2], m_periodic[2], m_expired[2], m_irq[2];
    int m_count[2], m_pre[2], m_q[2];

    function automatic bit is_jump(input logic [5:0] op);
        return op == 6'b010010 || op == 6'b010101 || op == 6'b111100 ||
               op == 6'b111101 || op == 6'b111110;
    endfunction

    task automatic model_init();
        for (int k = 0; k < 2; k++) begin
            m_en[k] = 1; m_periodic[k] = 1; m_expired[k] = 0; m_irq[k] = 0;
            m_count[k] = 0; m_pre[k] = 0; m_q[k] = 128;
        end
    endtask

    task automatic model_step(input int k);
        int ticks_per_count;
        ticks_per_count = (k == 0) ? 1 : 4;
        if (cfg_we && cfg_sel && !cfg_data[0]) begin
            m_en[k] = 0; m_expired[k] = 0; m_irq[k] = 0;
            m_count[k] = 0; m_pre[k] = 0; m_periodic[k] = cfg_data[1];
        end else begin
            if (!m_en[k]) begin
                m_count[k] = 0; m_pre[k] = 0;
            end else if (m_irq[k]) begin
                if (irq_ack) begin
                    m_irq[k] = 0; m_count[k] = 0; m_pre[k] = 0;
                    if (!m_periodic[k]) m_en[k] = 0;
                end
            end else if (m_expired[k]) begin
                if (!isUser) begin
                    m_expired[k] = 0; m_count[k] = 0; m_pre[k] = 0;
                end else if (!is_jump(opcode)) begin
                    m_expired[k] = 0; m_irq[k] = 1;
                end
            end else if (!isUser) begin
                m_count[k] = 0; m_pre[k] = 0;
            end else begin
                m_pre[k]++;
                if (m_pre[k] == ticks_per_count) begin
                    m_pre[k] = 0;
                    m_count[k] = (m_count[k] + 1) % 256;
                    if (m_q[k] != 0 && m_count[k] == m_q[k]) m_expired[k] = 1;
                end
            end
            if (cfg_we && !cfg_sel) m_q[k] = cfg_data;
            if (cfg_we && cfg_sel) begin
                m_periodic[k] = cfg_data[1];
                m_en[k] = 1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[25];
        int   edges;
        bit   bad;
        bit   wrapped;
        logic [7:0] prev;

        // ---- table: Q=3 expiry, jump deferral, ack, drop to kernel, stray ack, disable, re-enable
        vecs[0]  = mk(0, 6'o00, 1, 0, 8'd3, 0, 0, 0);
        vecs[1]  = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 1);
        vecs[2]  = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 2);
        vecs[3]  = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 3);
        vecs[4]  = mk(1, 6'b111110, 0, 0, 8'd0, 0, 0, 3);
        vecs[5]  = mk(1, 6'b010010, 0, 0, 8'd0, 0, 0, 3);
        vecs[6]  = mk(1, 6'b010101, 0, 0, 8'd0, 0, 0, 3);
        vecs[7]  = mk(1, 6'b111101, 0, 0, 8'd0, 0, 0, 3);
        vecs[8]  = mk(1, 6'b000001, 0, 0, 8'd0, 0, 1, 3);
        vecs[9]  = mk(0, 6'b111100, 0, 0, 8'd0, 0, 1, 3);
        vecs[10] = mk(1, 6'o00, 0, 0, 8'd0, 1, 0, 0);
        vecs[11] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 1);
        vecs[12] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 2);
        vecs[13] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 3);
        vecs[14] = mk(0, 6'o00, 0, 0, 8'd0, 0, 0, 0);
        vecs[15] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 1);
        vecs[16] = mk(1, 6'o00, 0, 0, 8'd0, 1, 0, 2);
        vecs[17] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 3);
        vecs[18] = mk(1, 6'o00, 0, 0, 8'd0, 0, 1, 3);
        vecs[19] = mk(1, 6'o00, 1, 1, 8'd0, 1, 0, 0);
        vecs[20] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 0);
        vecs[21] = mk(1, 6'o00, 1, 1, 8'd3, 0, 0, 0);
        vecs[22] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 1);
        vecs[23] = mk(1, 6'o00, 1, 0, 8'd1, 0, 0, 2);
        vecs[24] = mk(1, 6'o00, 0, 0, 8'd0, 0, 0, 3);

        do_reset();
        for (int i = 0; i < 25; i++) begin
            isUser = vecs[i].user; opcode = vecs[i].op; cfg_we = vecs[i].we;
            cfg_sel = vecs[i].sel; cfg_data = vecs[i].data; irq_ack = vecs[i].ack;
            step();
            check($sformatf("vec%0d irq", i), {31'd0, irq_a}, {31'd0, vecs[i].exp_irq});
            check($sformatf("vec%0d count", i), {24'd0, count_a}, {24'd0, vecs[i].exp_count});
        end

        // ---- defaults: irq after edge 129, again 129 edges after ack
        do_reset();
        isUser = 1'b1;
        run_until_irq(0, 300, edges);
        check("t1 first irq edge", edges, 129);
        check("t1 count held", {24'd0, count_a}, 32'd128);
        irq_ack = 1'b1;
        step();
        check("t1 irq after ack", {31'd0, irq_a}, 32'd0);
        check("t1 count after ack", {24'd0, count_a}, 32'd0);
        run_until_irq(0, 300, edges);
        check("t1 second irq edge", edges, 129);

        // ---- Q=10, jump in flight for 3 cycles at expiry
        do_reset();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd10;
        step();
        isUser = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t2 count at expiry", {24'd0, count_a}, 32'd10);
        check("t2 irq at expiry", {31'd0, irq_a}, 32'd0);
        opcode = 6'b111100;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (irq_a) bad = 1;
        end
        check("t2 irq deferred", {31'd0, bad}, 32'd0);
        opcode = 6'd0;
        step();
        check("t2 irq after edge 14", {31'd0, irq_a}, 32'd1);

        // ---- isUser drop at count 50
        do_reset();
        isUser = 1'b1;
        for (int i = 0; i < 50; i++) step();
        check("t3 count 50", {24'd0, count_a}, 32'd50);
        isUser = 1'b0;
        step();
        check("t3 count cleared", {24'd0, count_a}, 32'd0);
        isUser = 1'b1;
        run_until_irq(0, 300, edges);
        check("t3 irq edge", edges, 129);

        // ---- one-shot mode
        do_reset();
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 8'h01;
        step();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd10;
        step();
        isUser = 1'b1;
        run_until_irq(0, 100, edges);
        check("t4 irq edge", edges, 11);
        irq_ack = 1'b1;
        step();
        check("t4 irq after ack", {31'd0, irq_a}, 32'd0);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (irq_a || count_a != 8'd0) bad = 1;
        end
        check("t4 idle stays quiet", {31'd0, bad}, 32'd0);

        // ---- async reset while pending
        do_reset();
        isUser = 1'b1;
        run_until_irq(0, 300, edges);
        check("t5 pending reached", edges, 129);
        #2 reset = 1'b0;
        #1;
        check("t5 async irq", {31'd0, irq_a}, 32'd0);
        check("t5 async count", {24'd0, count_a}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_until_irq(0, 300, edges);
        check("t5 quantum back to 128", edges, 129);

        // ---- Q=0 never expires, count wraps
        do_reset();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd0;
        step();
        isUser = 1'b1;
        bad = 0; wrapped = 0; prev = count_a;
        for (int i = 0; i < 600; i++) begin
            step();
            if (irq_a) bad = 1;
            if (prev == 8'd255 && count_a == 8'd0) wrapped = 1;
            prev = count_a;
        end
        check("t6 no irq with Q=0", {31'd0, bad}, 32'd0);
        check("t6 count wrapped", {31'd0, wrapped}, 32'd1);
        check("t6 count after 600", {24'd0, count_a}, 32'd88);

        // ---- PRESCALE=4, Q=3
        do_reset();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd3;
        step();
        isUser = 1'b1;
        run_until_irq(1, 100, edges);
        check("t6b prescaled irq edge", edges, 13);

        // ---- randomized run against the model
        do_reset();
        model_init();
        for (int c = 0; c < 3000; c++) begin
            isUser = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: opcode = 6'b010010;
                    1: opcode = 6'b010101;
                    2: opcode = 6'b111100;
                    3: opcode = 6'b111101;
                    default: opcode = 6'b111110;
                endcase
            end else begin
                opcode = 6'($urandom_range(0, 63));
            end
            cfg_we = ($urandom_range(0, 39) == 0);
            cfg_sel = 1'($urandom_range(0, 1));
            if (!cfg_sel) cfg_data = 8'($urandom_range(0, 20));
            else cfg_data = {6'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
            irq_ack = (irq_a && $urandom_range(0, 2) == 0) || ($urandom_range(0, 49) == 0);
            model_step(0);
            model_step(1);
            step();
            check("rand irq_a", {31'd0, irq_a}, {31'd0, m_irq[0]});
            check("rand count_a", {24'd0, count_a}, m_count[0]);
            check("rand irq_b", {31'd0, irq_b}, {31'd0, m_irq[1]});
            check("rand count_b", {24'd0, count_b}, m_count[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
